// File: rtl/spectag_allocator_pkg.sv
// ============================================================================
// Module  : spectag_allocator_pkg
// Brief   : Shared widths and limits for the speculative-tag allocator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package spectag_allocator_pkg;

  localparam int SPECTAG_LEN = 5;
  localparam int MAX_BRDEPTH = SPECTAG_LEN - 1;
  localparam int BRDEPTH_LEN = 3;

  typedef logic [SPECTAG_LEN-1:0] spectag_t;
  typedef logic [BRDEPTH_LEN-1:0] brdepth_t;

endpackage

`default_nettype wire

// File: rtl/spectag_rotl.sv
// ============================================================================
// Module  : spectag_rotl
// Brief   : One-hot rotate-left by a fixed SHIFT; the top bit wraps to bit 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spectag_rotl #(
  parameter int WIDTH = 5,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = {din[WIDTH-1-SHIFT:0], din[WIDTH-1:WIDTH-SHIFT]};

endmodule

`default_nettype wire

// File: rtl/spectag_allocator.sv
// ============================================================================
// Module  : spectag_allocator
// Brief   : Allocates one-hot branch spectags for up to two branches per
//           dispatch group; optional SPECTAG_STATS_EN adds stall/miss counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spectag_allocator
  import spectag_allocator_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dispatch_en,
  input  logic                   inst1_isbranch,
  input  logic                   inst2_isbranch,
  input  logic                   prsuccess,
  input  logic                   prmiss,
  input  logic [SPECTAG_LEN-1:0] prtag,
  output logic [SPECTAG_LEN-1:0] inst1_spectag,
  output logic [SPECTAG_LEN-1:0] inst2_spectag,
  output logic [SPECTAG_LEN-1:0] setspec1_tag,
  output logic                   setspec1_en,
  output logic [SPECTAG_LEN-1:0] setspec2_tag,
  output logic                   setspec2_en,
  output logic                   attachable,
  output logic [BRDEPTH_LEN-1:0] brdepth
`ifdef SPECTAG_STATS_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            miss_cnt
`endif
);

  spectag_t r_tagreg;
  brdepth_t r_brdepth;

  spectag_t w_rot1;
  spectag_t w_rot2;
  logic [1:0] w_nbr;
  logic [3:0] w_need;
  logic [1:0] w_alloc;
  logic       w_dec;
  brdepth_t   w_depth_inc;
  brdepth_t   w_depth_next;
  spectag_t   w_tag_next;

  spectag_rotl #(.WIDTH(SPECTAG_LEN), .SHIFT(1)) u_rot1 (.din(r_tagreg), .dout(w_rot1));
  spectag_rotl #(.WIDTH(SPECTAG_LEN), .SHIFT(2)) u_rot2 (.din(r_tagreg), .dout(w_rot2));

  assign setspec1_tag  = w_rot1;
  assign setspec2_tag  = inst1_isbranch ? w_rot2 : w_rot1;
  assign inst1_spectag = r_tagreg;
  assign inst2_spectag = inst1_isbranch ? w_rot1 : r_tagreg;

  // Depth check uses the pre-resolution depth, so a coincident prsuccess
  // never frees a slot for the same group.
  assign w_nbr      = {1'b0, inst1_isbranch} + {1'b0, inst2_isbranch};
  assign w_need     = {1'b0, r_brdepth} + {2'b00, w_nbr};
  assign attachable = (w_need <= 4'(MAX_BRDEPTH));

  assign setspec1_en = dispatch_en & attachable & inst1_isbranch & ~prmiss;
  assign setspec2_en = dispatch_en & attachable & inst2_isbranch & ~prmiss;

  assign w_alloc      = {1'b0, setspec1_en} + {1'b0, setspec2_en};
  assign w_dec        = prsuccess & (r_brdepth != '0);
  assign w_depth_inc  = r_brdepth + {1'b0, w_alloc};
  assign w_depth_next = w_depth_inc - {{(BRDEPTH_LEN-1){1'b0}}, w_dec};

  always_comb begin
    w_tag_next = r_tagreg;
    if (setspec2_en)
      w_tag_next = setspec2_tag;
    else if (setspec1_en)
      w_tag_next = setspec1_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tagreg  <= spectag_t'(1);
      r_brdepth <= '0;
    end else if (prmiss) begin
      r_tagreg  <= prtag;
      r_brdepth <= '0;
    end else begin
      r_tagreg  <= w_tag_next;
      r_brdepth <= w_depth_next;
    end
  end

  assign brdepth = r_brdepth;

`ifdef SPECTAG_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_stall;

  assign w_stall = dispatch_en & ~attachable & (w_nbr != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (prmiss && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign miss_cnt  = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/spectag_allocator.md
Name: spectag_allocator

Overview:
- Producer side of the speculative-tag protocol.
- At dispatch it allocates one-hot branch spectags for up to two branches per cycle from a rotating ring, and drives the setspec1/setspec2 tag/enable pairs into the miss-prediction fix table.
- Tracks outstanding branch depth, labels every dispatched instruction with its governing spectag, and throttles dispatch when the ring is exhausted.
- Recovers ring state on branch resolution (prsuccess/prmiss).

Parameters:
- SPECTAG_LEN, 5, one-hot tag width = ring size.
- MAX_BRDEPTH, SPECTAG_LEN-1 = 4, maximum outstanding unresolved branches; one tag is always reserved as the current base.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- dispatch_en  in  1  decode group advances this cycle; no downstream stall.
- inst1_isbranch  in  1  slot-1 instruction is a valid branch.
- inst2_isbranch  in  1  slot-2 instruction is a valid branch.
- prsuccess  in  1  oldest outstanding branch predicted correctly.
- prmiss  in  1  oldest outstanding branch mispredicted.
- prtag  in  SPECTAG_LEN  tag of the resolving branch.
- inst1_spectag  out  SPECTAG_LEN  tag governing slot-1 instruction.
- inst2_spectag  out  SPECTAG_LEN  tag governing slot-2 instruction.
- setspec1_tag  out  SPECTAG_LEN  tag allocated to the slot-1 branch.
- setspec1_en  out  1  slot-1 allocation is committed this cycle.
- setspec2_tag  out  SPECTAG_LEN  tag allocated to the slot-2 branch.
- setspec2_en  out  1  slot-2 allocation is committed this cycle.
- attachable  out  1  the current group's branches fit in the ring.
- brdepth  out  3  outstanding branch count, 0..MAX_BRDEPTH.

Behaviour:
- State: tagreg (one-hot, current base tag) and brdepth counter.
- Reset: tagreg=5'b00001, brdepth=0. All outputs follow combinationally: inst1_spectag=5'b00001, setspec*_en=0, attachable=1.
- Combinational outputs, zero latency:
  - setspec1_tag = rotl(tagreg,1).
  - setspec2_tag = inst1_isbranch ? rotl(tagreg,2) : rotl(tagreg,1).
  - inst1_spectag = tagreg.
  - inst2_spectag = inst1_isbranch ? setspec1_tag : tagreg.
- Rotation wraps: bit SPECTAG_LEN-1 rotates to bit 0.
- nbr = inst1_isbranch + inst2_isbranch, range 0..2.
- attachable = (brdepth + nbr <= MAX_BRDEPTH), evaluated with a 4-bit sum to avoid overflow.
- setspec1_en = dispatch_en & attachable & inst1_isbranch & ~prmiss. setspec2_en is the same, using inst2_isbranch.
- Group is all-or-nothing: if attachable=0, neither slot allocates. Upstream must hold the group; the block does not stall itself.
- Next-state priority, highest first:
  1. reset.
  2. prmiss: tagreg<=prtag, brdepth<=0. The same-cycle dispatch is discarded, consistent with the fix table clearing all valid bits on prmiss.
  3. Otherwise, with alloc = number of asserted setspec_en and dec = prsuccess:
     - brdepth <= brdepth + alloc - dec.
     - tagreg <= last allocated tag when alloc>0, else unchanged.
- prsuccess at brdepth=0 is a protocol error: brdepth holds at 0, no underflow.
- Contract: resolution is reported in order, so prtag is always the oldest outstanding tag.
- prsuccess together with a 2-branch allocation at brdepth=3: attachable uses the pre-decrement depth (3+2>4), so no allocation occurs. Conservative by design.

Optional Feature:
- Macro SPECTAG_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and miss_cnt[31:0].
  - stall_cnt increments each cycle with dispatch_en & ~attachable & (nbr>0).
  - miss_cnt increments on prmiss.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared constants file: SPECTAG_LEN, MAX_BRDEPTH, BRDEPTH_LEN (3).
- Sub-module spectag_rotl: parameterised one-hot rotate-left by 1 or 2, instantiated twice.

Test Plan:
- Reset, then 1 slot-1 branch dispatched → setspec1_tag=5'b00010, setspec1_en=1; next cycle tagreg=5'b00010, brdepth=1.
- Two-branch group from tagreg=5'b01000 → setspec1_tag=5'b10000, setspec2_tag=5'b00001 (wrap); inst2_spectag=5'b10000; brdepth +2.
- brdepth=3 with a two-branch group → attachable=0, both setspec_en=0, state unchanged. Same group after one prsuccess → allocated, brdepth=4.
- prmiss with prtag=5'b00100 in the same cycle as a one-branch dispatch → setspec1_en=0; next cycle tagreg=5'b00100, brdepth=0.
- prsuccess coincident with a single-branch allocation at brdepth=2 → brdepth stays 2, tagreg advances one position.
- SPECTAG_STATS_EN build: 3 blocked branch cycles plus 1 prmiss → stall_cnt=3, miss_cnt=1; reset clears both.
